// File: rtl/regfile_wb_arbiter_pkg.sv
// ============================================================================
// Package : regfile_wb_pkg
// Shared widths and request types for the register-file writeback arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package regfile_wb_pkg;

  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 4;
  localparam int NREG  = 2 ** AW;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  typedef logic [PW-1:0] wb_ptr_t;

endpackage

`default_nettype wire

// File: rtl/regfile_wb_arbiter_fifo.sv
// ============================================================================
// Module : wb_fifo
// Two-push / one-pop writeback queue; entries exported oldest-first.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_fifo
  import regfile_wb_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push0,
  input  wb_req_t       i_req0,
  input  logic          i_push1,
  input  wb_req_t       i_req1,
  input  logic          i_pop,
  output logic [CW-1:0] o_count,
  output wb_req_t       o_entries [DEPTH]
);

  wb_req_t       r_mem [DEPTH];
  wb_ptr_t       r_wr_ptr;
  wb_ptr_t       r_rd_ptr;
  logic [CW-1:0] r_count;
  wb_ptr_t       w_wr_ptr1;
  logic          w_pop;

  assign w_pop     = i_pop && (r_count != '0);
  // Second push lands behind the first one, or at the tail if the first is absent.
  assign w_wr_ptr1 = r_wr_ptr + wb_ptr_t'(i_push0);

  always_ff @(posedge clk) begin
    if (i_push0) r_mem[r_wr_ptr] <= i_req0;
    if (i_push1) r_mem[w_wr_ptr1] <= i_req1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + wb_ptr_t'(i_push0) + wb_ptr_t'(i_push1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + wb_ptr_t'(1);
      r_count  <= r_count + CW'(i_push0) + CW'(i_push1) - CW'(w_pop);
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      o_entries[i] = r_mem[r_rd_ptr + wb_ptr_t'(i)];
    end
  end

  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// Module : regfile_wb_arbiter
// Queues ALU/load writebacks onto the single RF write port and tracks pending
// destination registers. Optional forwarding search: REGFILE_WB_FWD_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_wb_arbiter
  import regfile_wb_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_alu_valid,
  output logic            o_alu_ready,
  input  logic [AW-1:0]   i_alu_rd,
  input  logic [XLEN-1:0] i_alu_data,
  input  logic            i_ld_valid,
  output logic            o_ld_ready,
  input  logic [AW-1:0]   i_ld_rd,
  input  logic [XLEN-1:0] i_ld_data,
`ifdef REGFILE_WB_FWD_EN
  input  logic [AW-1:0]   i_chk_addr1,
  input  logic [AW-1:0]   i_chk_addr2,
  output logic            o_fwd_hit1,
  output logic            o_fwd_hit2,
  output logic [XLEN-1:0] o_fwd_val1,
  output logic [XLEN-1:0] o_fwd_val2,
`endif
  output logic            o_rf_w,
  output logic [AW-1:0]   o_rf_write_addr,
  output logic [XLEN-1:0] o_rf_write_val,
  output logic [NREG-1:0] o_pend_mask
);

  logic [CW-1:0] w_count;
  logic [CW-1:0] w_free;
  wb_req_t       w_entries [DEPTH];
  wb_req_t       w_ld_req;
  wb_req_t       w_alu_req;
  logic          w_ld_push;
  logic          w_alu_push;
  logic          w_pop;

  // Free space ignores the same-cycle pop, so readiness never depends on the drain.
  assign w_free      = CW'(DEPTH) - w_count;
  assign o_ld_ready  = rst && (w_free != '0);
  assign o_alu_ready = rst && ((w_free >= CW'(2)) || ((w_free == CW'(1)) && !i_ld_valid));

  assign w_ld_push  = i_ld_valid && o_ld_ready && (i_ld_rd != '0);
  assign w_alu_push = i_alu_valid && o_alu_ready && (i_alu_rd != '0);
  assign w_ld_req   = '{rd: i_ld_rd, data: i_ld_data};
  assign w_alu_req  = '{rd: i_alu_rd, data: i_alu_data};
  assign w_pop      = (w_count != '0);

  wb_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push0   (w_ld_push),
    .i_req0    (w_ld_req),
    .i_push1   (w_alu_push),
    .i_req1    (w_alu_req),
    .i_pop     (w_pop),
    .o_count   (w_count),
    .o_entries (w_entries)
  );

  assign o_rf_w          = w_pop;
  assign o_rf_write_addr = w_pop ? w_entries[0].rd   : '0;
  assign o_rf_write_val  = w_pop ? w_entries[0].data : '0;

  assign o_pend_mask[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_pend
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_inc;
    logic          w_dec;

    assign w_inc = CW'(w_ld_push && (i_ld_rd == AW'(r)))
                 + CW'(w_alu_push && (i_alu_rd == AW'(r)));
    assign w_dec = w_pop && (w_entries[0].rd == AW'(r));

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_cnt <= '0;
      else      r_cnt <= r_cnt + w_inc - CW'(w_dec);
    end

    assign o_pend_mask[r] = (r_cnt != '0);
  end

`ifdef REGFILE_WB_FWD_EN
  assign o_fwd_hit1 = o_pend_mask[i_chk_addr1];
  assign o_fwd_hit2 = o_pend_mask[i_chk_addr2];

  // Scan oldest to youngest so the last match wins.
  always_comb begin
    o_fwd_val1 = '0;
    o_fwd_val2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < w_count) && (w_entries[i].rd == i_chk_addr1)) o_fwd_val1 = w_entries[i].data;
      if ((CW'(i) < w_count) && (w_entries[i].rd == i_chk_addr2)) o_fwd_val2 = w_entries[i].data;
    end
  end
`else
  logic w_unused_entries;
  always_comb begin
    w_unused_entries = 1'b0;
    for (int i = 1; i < DEPTH; i++) w_unused_entries = w_unused_entries ^ (^w_entries[i]);
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ============================================================================
// Module : tb_regfile_wb_arbiter
// Directed bench for regfile_wb_arbiter with a write-order scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alu_valid = 1'b0, ld_valid = 1'b0;
  logic [4:0]  alu_rd = '0, ld_rd = '0;
  logic [31:0] alu_data = '0, ld_data = '0;
  logic        alu_ready, ld_ready;
  logic        rf_w;
  logic [4:0]  rf_addr;
  logic [31:0] rf_val;
  logic [31:0] pend_mask;
`ifdef REGFILE_WB_FWD_EN
  logic [4:0]  chk_addr1 = '0, chk_addr2 = '0;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_val1, fwd_val2;
`endif

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [36:0] exp_q[$];

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .i_alu_valid     (alu_valid),
    .o_alu_ready     (alu_ready),
    .i_alu_rd        (alu_rd),
    .i_alu_data      (alu_data),
    .i_ld_valid      (ld_valid),
    .o_ld_ready      (ld_ready),
    .i_ld_rd         (ld_rd),
    .i_ld_data       (ld_data),
`ifdef REGFILE_WB_FWD_EN
    .i_chk_addr1     (chk_addr1),
    .i_chk_addr2     (chk_addr2),
    .o_fwd_hit1      (fwd_hit1),
    .o_fwd_hit2      (fwd_hit2),
    .o_fwd_val1      (fwd_val1),
    .o_fwd_val2      (fwd_val2),
`endif
    .o_rf_w          (rf_w),
    .o_rf_write_addr (rf_addr),
    .o_rf_write_val  (rf_val),
    .o_pend_mask     (pend_mask)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic drv(input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                     input logic av, input logic [4:0] ard, input logic [31:0] adat);
    ld_valid  = lv;  ld_rd  = lrd; ld_data  = ldat;
    alu_valid = av;  alu_rd = ard; alu_data = adat;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every RF write must match the oldest expected entry.
  always @(negedge clk) begin
    logic [36:0] e;
    if (rst !== 1'b1) begin
      chk("rf_w_in_reset", {31'd0, rf_w}, 64'd0);
    end else if (rf_w === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_write: got x%0d=%0h, required no write (t=%0t)", rf_addr, rf_val, $time);
      end else begin
        e = exp_q.pop_front();
        chk("wb_addr", {59'd0, rf_addr}, {59'd0, e[36:32]});
        chk("wb_val", {32'd0, rf_val}, {32'd0, e[31:0]});
      end
    end else begin
      chk("idle_port", {27'd0, rf_addr, rf_val}, 64'd0);
    end
  end

  initial begin
    logic exp_ar [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    // Reset with both requesters active.
    drv(1'b1, 5'd0, 32'h0, 1'b1, 5'd0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ld_ready", {63'd0, ld_ready}, 64'd0);
    chk("rst_alu_ready", {63'd0, alu_ready}, 64'd0);
    chk("rst_pend", {32'd0, pend_mask}, 64'd0);
    tick;
    rst = 1'b1;
    @(negedge clk);
    chk("rel_ld_ready", {63'd0, ld_ready}, 64'd1);
    chk("rel_alu_ready", {63'd0, alu_ready}, 64'd1);
    tick;
    drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    chk("rd0_no_write", {63'd0, rf_w}, 64'd0);
    tick;

    // Single ALU write, one-cycle latency.
    drv(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF);
    exp_q.push_back({5'd5, 32'hDEADBEEF});
    tick;
    drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    chk("lat_rf_w", {63'd0, rf_w}, 64'd1);
    chk("lat_pend5", {32'd0, pend_mask}, 64'h20);
    tick;
    @(negedge clk);
    chk("lat_rf_w_off", {63'd0, rf_w}, 64'd0);
    chk("lat_pend_clr", {32'd0, pend_mask}, 64'd0);
    tick;

    // Dual push: load enqueued before ALU; then a dual rd=0 handshake.
    drv(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
    exp_q.push_back({5'd3, 32'h11});
    exp_q.push_back({5'd4, 32'h22});
    tick;
    drv(1'b1, 5'd0, 32'h99, 1'b1, 5'd0, 32'h98);
    @(negedge clk);
    chk("dual_rd0_ld_ready", {63'd0, ld_ready}, 64'd1);
    chk("dual_rd0_alu_ready", {63'd0, alu_ready}, 64'd1);
    tick;
    drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    repeat (3) tick;
    chk("dual_drained", 64'(exp_q.size()), 64'd0);

    // Back-to-back pressure until the queue fills.
    for (int k = 0; k < 5; k++) begin
      drv(1'b1, 5'(10 + k), 32'hA000_0000 | 32'(k), 1'b1, 5'(20 + k), 32'hB000_0000 | 32'(k));
      exp_q.push_back({5'(10 + k), 32'hA000_0000 | 32'(k)});
      if (exp_ar[k]) exp_q.push_back({5'(20 + k), 32'hB000_0000 | 32'(k)});
      @(negedge clk);
      chk("fill_ld_ready", {63'd0, ld_ready}, 64'd1);
      chk("fill_alu_ready", {63'd0, alu_ready}, {63'd0, exp_ar[k]});
      if (k == 2) chk("fill_pend", {32'd0, pend_mask}, 64'h0030_0800);
      tick;
    end
    drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    repeat (4) tick;
    @(negedge clk);
    chk("fill_pend_clr", {32'd0, pend_mask}, 64'd0);
    chk("fill_drained", 64'(exp_q.size()), 64'd0);
    tick;

    // Reset with three entries queued: none of them may reach the RF.
    drv(1'b1, 5'd6, 32'h66, 1'b1, 5'd7, 32'h77);
    exp_q.push_back({5'd6, 32'h66});
    tick;
    drv(1'b1, 5'd8, 32'h88, 1'b1, 5'd9, 32'h99);
    @(negedge clk);
    chk("pre_rst_pend", {32'd0, pend_mask}, 64'hC0);
    tick;
    drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    rst = 1'b0;
    #1;
    chk("midrst_rf_w", {63'd0, rf_w}, 64'd0);
    chk("midrst_pend", {32'd0, pend_mask}, 64'd0);
    chk("midrst_ld_ready", {63'd0, ld_ready}, 64'd0);
    repeat (2) tick;
    rst = 1'b1;
    repeat (5) tick;
    chk("post_rst_drained", 64'(exp_q.size()), 64'd0);

`ifdef REGFILE_WB_FWD_EN
    // Two queued writes to x7: forwarding must return the younger one.
    drv(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
    exp_q.push_back({5'd1, 32'h1});
    exp_q.push_back({5'd2, 32'h2});
    tick;
    drv(1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB);
    exp_q.push_back({5'd7, 32'hA});
    exp_q.push_back({5'd7, 32'hB});
    tick;
    drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk_addr1 = 5'd7;
    chk_addr2 = 5'd2;
    @(negedge clk);
    chk("fwd_hit1", {63'd0, fwd_hit1}, 64'd1);
    chk("fwd_val1", {32'd0, fwd_val1}, 64'hB);
    chk("fwd_hit2", {63'd0, fwd_hit2}, 64'd1);
    chk("fwd_val2", {32'd0, fwd_val2}, 64'h2);
    chk_addr1 = 5'd0;
    #1;
    chk("fwd_x0_hit", {63'd0, fwd_hit1}, 64'd0);
    chk("fwd_x0_val", {32'd0, fwd_val1}, 64'd0);
    repeat (4) tick;
    chk("fwd_drained", 64'(exp_q.size()), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
